// File: rtl/washu_dbg_monitor_if.sv
// Observation/control bundle between the washu debug monitor and its environment.
// The slave side is the monitor itself; the master side is the CPU/board harness.
interface washu_dbg_monitor_if;
    logic        run_req;
    logic        step_req;
    logic        sel_hold;
    logic [1:0]  sel_sw;
    logic [15:0] dispReq;
    logic        pause;
    logic [1:0]  regSelect;
    logic [3:0]  snap_valid;
    logic [15:0] cur_value;
    logic [3:0]  an;
    logic [6:0]  seg;

    modport master (
        output run_req, step_req, sel_hold, sel_sw, dispReq,
        input  pause, regSelect, snap_valid, cur_value, an, seg
    );

    modport slave (
        input  run_req, step_req, sel_hold, sel_sw, dispReq,
        output pause, regSelect, snap_valid, cur_value, an, seg
    );
endinterface

// File: rtl/washu_dbg_monitor.sv
// washu debug monitor: pause/single-step control of the CPU, round-robin capture of
// the four observable registers into snapshots, and a 4-digit seven-segment scanner.
module washu_dbg_monitor #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SCAN_DIV      = 1000
) (
    input  logic                clk,
    input  logic                reset,
    washu_dbg_monitor_if.slave  bus
);

    typedef enum logic [1:0] {StRun, StHalt, StStep} pause_state_e;
    typedef enum logic {StSet, StCap} scan_state_e;

    localparam logic [3:0]  SettleLast = 4'(SETTLE_CYCLES - 1);
    localparam logic [15:0] PrescLast  = 16'(SCAN_DIV - 1);

    // Pause control
    pause_state_e pause_state_q;
    logic         pause_q;
    logic         step_q;
    logic         step_rise;

    // Register scan / snapshots
    scan_state_e      scan_state_q;
    logic [3:0]       settle_cnt_q;
    logic [1:0]       idx_q;
    logic [1:0]       next_idx;
    logic [3:0][15:0] snap_q;
    logic [3:0]       snap_valid_q;
    logic [15:0]      cur_value;

    // Display scanner
    logic [15:0] presc_q;
    logic        presc_wrap;
    logic [1:0]  dig_q;
    logic [1:0]  dig_d;
    logic [3:0]  nibble;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign step_rise = bus.step_req & ~step_q;

    // Pause FSM: step edges only count while halted; a step lasts exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_state_q <= StHalt;
            pause_q       <= 1'b1;
            step_q        <= 1'b0;
        end else begin
            step_q <= bus.step_req;
            case (pause_state_q)
                StRun: begin
                    if (!bus.run_req) begin
                        pause_state_q <= StHalt;
                        pause_q       <= 1'b1;
                    end
                end
                StHalt: begin
                    if (bus.run_req) begin
                        pause_state_q <= StRun;
                        pause_q       <= 1'b0;
                    end else if (step_rise) begin
                        pause_state_q <= StStep;
                        pause_q       <= 1'b0;
                    end
                end
                StStep: begin
                    pause_state_q <= StHalt;
                    pause_q       <= 1'b1;
                end
                default: begin
                    pause_state_q <= StHalt;
                    pause_q       <= 1'b1;
                end
            endcase
        end
    end

    // Index to select after a capture: locked switch value or round-robin.
    always_comb begin
        next_idx = idx_q + 2'd1;
        if (bus.sel_hold) begin
            next_idx = bus.sel_sw;
        end
    end

    // Scan FSM: hold regSelect for the settle time, then capture dispReq for that index.
    // A switch change while settling restarts the settle so data always matches the select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_state_q <= StSet;
            settle_cnt_q <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            snap_valid_q <= '0;
        end else begin
            case (scan_state_q)
                StSet: begin
                    if (bus.sel_hold && (bus.sel_sw != idx_q)) begin
                        idx_q        <= bus.sel_sw;
                        settle_cnt_q <= '0;
                    end else if (settle_cnt_q == SettleLast) begin
                        scan_state_q <= StCap;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end
                StCap: begin
                    snap_q[idx_q]       <= bus.dispReq;
                    snap_valid_q[idx_q] <= 1'b1;
                    settle_cnt_q        <= '0;
                    idx_q               <= next_idx;
                    scan_state_q        <= StSet;
                end
                default: begin
                    scan_state_q <= StSet;
                    settle_cnt_q <= '0;
                end
            endcase
        end
    end

    assign cur_value = snap_q[bus.sel_sw];

    // Next digit and its nibble; an/seg are registered against the new digit so they stay aligned.
    always_comb begin
        presc_wrap = (presc_q == PrescLast);
        dig_d      = dig_q;
        if (presc_wrap) begin
            dig_d = dig_q + 2'd1;
        end
        nibble = cur_value[3:0];
        unique case (dig_d)
            2'd0: nibble = cur_value[3:0];
            2'd1: nibble = cur_value[7:4];
            2'd2: nibble = cur_value[11:8];
            default: nibble = cur_value[15:12];
        endcase
    end

    // Display prescaler, digit counter and registered segment/anode drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            dig_q   <= '0;
            an_q    <= 4'b1110;
            seg_q   <= 7'b1000000;
        end else begin
            presc_q <= presc_wrap ? 16'd0 : presc_q + 16'd1;
            dig_q   <= dig_d;
            an_q    <= ~(4'b0001 << dig_d);
            seg_q   <= hex_to_seg(nibble);
        end
    end

    assign bus.pause      = pause_q;
    assign bus.regSelect  = idx_q;
    assign bus.snap_valid = snap_valid_q;
    assign bus.cur_value  = cur_value;
    assign bus.an         = an_q;
    assign bus.seg        = seg_q;

endmodule

// File: tb/tb_washu_dbg_monitor.sv
// Bench for washu_dbg_monitor: a behavioural model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_washu_dbg_monitor;
    localparam int SETTLE = 2;
    localparam int DIV    = 4;

    logic clk;
    logic reset;
    washu_dbg_monitor_if dbg();

    washu_dbg_monitor #(
        .SETTLE_CYCLES(SETTLE),
        .SCAN_DIV(DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(dbg.slave)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // CPU model: 0 = 1000h+regSelect, 1 = {regSelect,2'b00,stamp}, 2 = constant A5C3h
    int          dmode = 0;
    logic [11:0] stamp = '0;

    assign dbg.dispReq = (dmode == 0) ? (16'h1000 + {14'b0, dbg.regSelect}) :
                         (dmode == 1) ? {dbg.regSelect, 2'b00, stamp} : 16'hA5C3;

    function automatic logic [15:0] cpu_val(input int idx);
        logic [1:0] i2;
        i2 = 2'(idx);
        if (dmode == 0) return 16'h1000 + 16'(idx);
        if (dmode == 1) return {i2, 2'b00, stamp};
        return 16'hA5C3;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        logic [6:0] tbl [16];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tbl[h];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(negedge clk);
        stamp = stamp + 12'd1;
    end

    // Behavioural model
    bit          m_pause = 1;
    bit          m_stepping = 0;
    bit          m_prev_step = 0;
    int          m_idx = 0;
    int          m_age = 0;
    logic [15:0] m_snap [4] = '{default: 16'h0};
    logic [3:0]  m_valid = '0;
    int          m_cyc = 0;
    logic [3:0]  m_an = 4'b1110;
    logic [6:0]  m_seg = 7'b1000000;

    initial forever begin
        logic [15:0] cur_pre;
        int          dig;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_pause = 1; m_stepping = 0; m_prev_step = 0;
            m_idx = 0; m_age = 0; m_valid = '0; m_cyc = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 16'h0;
            m_an = 4'b1110; m_seg = 7'b1000000;
        end else begin
            cur_pre = m_snap[dbg.sel_sw];
            // halt/run/step rules
            if (m_stepping) begin
                m_stepping = 0;
                m_pause = 1;
            end else if (!m_pause) begin
                if (!dbg.run_req) m_pause = 1;
            end else if (dbg.run_req) begin
                m_pause = 0;
            end else if (dbg.step_req && !m_prev_step) begin
                m_pause = 0;
                m_stepping = 1;
            end
            m_prev_step = dbg.step_req;
            // age = edges since the select was set; capture happens at age == SETTLE
            if (m_age < SETTLE && dbg.sel_hold && int'(dbg.sel_sw) != m_idx) begin
                m_idx = int'(dbg.sel_sw);
                m_age = 0;
            end else if (m_age == SETTLE) begin
                m_snap[m_idx] = cpu_val(m_idx);
                m_valid[m_idx] = 1'b1;
                m_idx = dbg.sel_hold ? int'(dbg.sel_sw) : (m_idx + 1) % 4;
                m_age = 0;
            end else begin
                m_age++;
            end
            // display: digit is purely a function of elapsed cycles
            m_cyc++;
            dig = (m_cyc / DIV) % 4;
            m_an = ~(4'b0001 << dig);
            m_seg = seg_of(cur_pre[dig*4 +: 4]);
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(posedge clk);
        #1;
        if (!reset && chk_en) begin
            chk("pause", 32'(dbg.pause), 32'(m_pause));
            chk("regSelect", 32'(dbg.regSelect), 32'(m_idx));
            chk("snap_valid", 32'(dbg.snap_valid), 32'(m_valid));
            chk("cur_value", 32'(dbg.cur_value), 32'(m_snap[dbg.sel_sw]));
            chk("an", 32'(dbg.an), 32'(m_an));
            chk("seg", 32'(dbg.seg), 32'(m_seg));
        end
    end

    // Directed scenarios
    initial begin
        int rs_exp [7];
        logic [3:0] an_tbl [4];
        logic [6:0] seg_tbl [4];
        int zeros;
        int ones;
        bit found;
        rs_exp  = '{0, 0, 0, 1, 1, 1, 2};
        an_tbl  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tbl = '{7'b0110000, 7'b1000110, 7'b0010010, 7'b0001000};

        reset = 1;
        dbg.run_req = 0; dbg.step_req = 0; dbg.sel_hold = 0; dbg.sel_sw = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pause_in_reset", 32'(dbg.pause), 32'd1);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rst_pause", 32'(dbg.pause), 32'd1);
        chk("rst_regSelect", 32'(dbg.regSelect), 32'd0);
        chk("rst_snap_valid", 32'(dbg.snap_valid), 32'd0);
        chk("rst_an", 32'(dbg.an), 32'b1110);
        chk("rst_seg", 32'(dbg.seg), 32'b1000000);
        chk("rst_cur_value", 32'(dbg.cur_value), 32'd0);
        chk_en = 1;

        // Auto-scan
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i <= 6) chk("scan_seq", 32'(dbg.regSelect), 32'(rs_exp[i]));
        end
        chk("scan_all_valid", 32'(dbg.snap_valid), 32'hF);
        @(negedge clk);
        dbg.sel_sw = 2;
        #1;
        chk("scan_cur_value", 32'(dbg.cur_value), 32'h1002);

        // Hold switch
        @(negedge clk);
        dbg.sel_hold = 1; dbg.sel_sw = 3; dmode = 1;
        repeat (8) @(negedge clk);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_idx == 3 && m_age == 0) begin
                found = 1;
                break;
            end
        end
        chk("hold_sync", 32'(found), 32'd1);
        dbg.sel_sw = 1;
        @(posedge clk);
        #1;
        chk("hold_switch_select", 32'(dbg.regSelect), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        dbg.sel_sw = 3;
        #1;
        chk("hold_snap3_not_stale", 32'(dbg.cur_value[15:14]), 32'd3);
        @(negedge clk);
        dbg.sel_hold = 0; dmode = 0;

        // Run / halt
        @(negedge clk);
        dbg.run_req = 1;
        @(posedge clk);
        #1;
        chk("run_pause0", 32'(dbg.pause), 32'd0);
        @(negedge clk);
        dbg.run_req = 0;
        @(posedge clk);
        #1;
        chk("halt_pause1", 32'(dbg.pause), 32'd1);

        // Single step while halted: held-high step gives one cycle only
        zeros = 0;
        @(negedge clk);
        dbg.step_req = 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (dbg.pause == 1'b0) zeros++;
        end
        @(negedge clk);
        dbg.step_req = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (dbg.pause == 1'b0) zeros++;
        end
        chk("step_one_cycle", 32'(zeros), 32'd1);

        // Same step sequence while running
        @(negedge clk);
        dbg.run_req = 1;
        @(posedge clk);
        ones = 0;
        @(negedge clk);
        dbg.step_req = 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (dbg.pause == 1'b1) ones++;
        end
        @(negedge clk);
        dbg.step_req = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (dbg.pause == 1'b1) ones++;
        end
        chk("step_in_run_ignored", 32'(ones), 32'd0);
        @(negedge clk);
        dbg.run_req = 0;

        // Display of A5C3h
        @(negedge clk);
        dmode = 2; dbg.sel_sw = 0;
        repeat (14) @(posedge clk);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (m_cyc % (4 * DIV) == 0) begin
                found = 1;
                break;
            end
        end
        chk("disp_sync", 32'(found), 32'd1);
        for (int i = 0; i < 4 * DIV; i++) begin
            chk("disp_an", 32'(dbg.an), 32'(an_tbl[i / DIV]));
            chk("disp_seg", 32'(dbg.seg), 32'(seg_tbl[i / DIV]));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-operation
        @(negedge clk);
        dbg.run_req = 1;
        repeat (5) @(posedge clk);
        #2;
        reset = 1;
        #1;
        chk("areset_pause", 32'(dbg.pause), 32'd1);
        chk("areset_regSelect", 32'(dbg.regSelect), 32'd0);
        chk("areset_snap_valid", 32'(dbg.snap_valid), 32'd0);
        chk("areset_cur_value", 32'(dbg.cur_value), 32'd0);
        chk("areset_an", 32'(dbg.an), 32'b1110);
        chk("areset_seg", 32'(dbg.seg), 32'b1000000);
        @(negedge clk);
        dbg.run_req = 0;
        reset = 0;
        repeat (6) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
